// File: rtl/vga_scan_timing.sv
// 640x480@60 raster timing: pixel divider, x/y counters, syncs, blank and frame strobe.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync/blank_n by one pixel behind the counters.
module vga_scan_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] counter_x,
  output logic [9:0] counter_y,
  output logic       pix_en,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div;
  logic [9:0]    r_x, r_y;
  logic          r_hs, r_vs, r_bl, r_fs;

  logic [9:0]    w_x_nxt, w_y_nxt;
  logic          w_x_wrap, w_hs_nxt, w_vs_nxt, w_bl_nxt;

  assign pix_en  = (r_div == DIV_LAST);
  assign vga_clk = (r_div >= DIV_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else if (pix_en) r_div <= '0;
    else r_div <= r_div + DW'(1);
  end

  // Syncs are derived from the next counts so they land on the same edge as the counters.
  always_comb begin
    w_x_wrap = (r_x == X_LAST);
    w_x_nxt  = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt  = r_y;
    if (w_x_wrap) w_y_nxt = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
    w_hs_nxt = !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
    w_vs_nxt = !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
    w_bl_nxt = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= X_LAST;
      r_y  <= Y_LAST;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_bl <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_fs <= pix_en && (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
      if (pix_en) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_hs <= w_hs_nxt;
        r_vs <= w_vs_nxt;
        r_bl <= w_bl_nxt;
      end
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  logic r_hs_d, r_vs_d, r_bl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_bl_d <= 1'b0;
    end else if (pix_en) begin
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_bl_d <= r_bl;
    end
  end

  assign hsync   = r_hs_d;
  assign vsync   = r_vs_d;
  assign blank_n = r_bl_d;
`else
  assign hsync   = r_hs;
  assign vsync   = r_vs;
  assign blank_n = r_bl;
`endif

  assign counter_x   = r_x;
  assign counter_y   = r_y;
  assign frame_start = r_fs;
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: full-size instance for reset/line timing,
// short-frame instance (V_TOTAL=12) so frame wrap and mid-frame reset fit a short run.
module tb_vga_scan_timing;

`ifdef VGA_SYNC_PIPE_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic clk, rst_n;
  logic [9:0] d_x, d_y, v_x, v_y;
  logic d_pe, d_vc, d_hs, d_vs, d_bl, d_sn, d_fs;
  logic v_pe, v_vc, v_hs, v_vs, v_bl, v_sn, v_fs;

  int n_total = 0;
  int n_bad   = 0;

  vga_scan_timing u_dut (
    .clk(clk), .rst_n(rst_n), .counter_x(d_x), .counter_y(d_y), .pix_en(d_pe),
    .vga_clk(d_vc), .hsync(d_hs), .vsync(d_vs), .blank_n(d_bl), .sync_n(d_sn),
    .frame_start(d_fs)
  );

  vga_scan_timing #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_dut_v (
    .clk(clk), .rst_n(rst_n), .counter_x(v_x), .counter_y(v_y), .pix_en(v_pe),
    .vga_clk(v_vc), .hsync(v_hs), .vsync(v_vs), .blank_n(v_bl), .sync_n(v_sn),
    .frame_start(v_fs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int pe_cnt, vc_cnt, hs_lo, hs_fall_x, hs_rise_x, bl_fall_x;
    logic p_hs, p_bl, p_vs;
    int cyc, npulse, t0, t1, vs_lo, bl_hi, fs_hi, max_x, max_y, vs_edges, vs_bad_x;
    bit found;

    // reset held for 5 clk
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_x", d_x, 799);
    chk("rst_y", d_y, 524);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_bl", d_bl, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_pe", d_pe, 0);
    chk("rst_vc", d_vc, 0);
    chk("rst_sn", d_sn, 0);
    chk("rst_vy", v_y, 11);

    // release: second edge wraps to (0,0)
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel1_x", d_x, 799);
    @(posedge clk);
    #1;
    chk("rel_x", d_x, 0);
    chk("rel_y", d_y, 0);
    chk("rel_bl", d_bl, (LAG == 0) ? 1 : 0);
    chk("rel_fs", d_fs, 1);
    @(posedge clk);
    #1 chk("rel_fs_off", d_fs, 0);

    // one full line on the full-size instance
    pe_cnt = 0; vc_cnt = 0; hs_lo = 0;
    hs_fall_x = -1; hs_rise_x = -1; bl_fall_x = -1;
    p_hs = d_hs; p_bl = d_bl;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (d_pe) pe_cnt++;
      if (d_vc) vc_cnt++;
      if (!d_hs) hs_lo++;
      if (p_hs && !d_hs && hs_fall_x < 0) hs_fall_x = int'(d_x);
      if (!p_hs && d_hs && hs_rise_x < 0) hs_rise_x = int'(d_x);
      if (p_bl && !d_bl && bl_fall_x < 0) bl_fall_x = int'(d_x);
      p_hs = d_hs; p_bl = d_bl;
    end
    chk("line_pe_cnt", pe_cnt, 800);
    chk("line_vc_hi", vc_cnt, 800);
    chk("hs_low_clk", hs_lo, 192);
    chk("hs_fall_x", hs_fall_x, 656 + LAG);
    chk("hs_rise_x", hs_rise_x, 752 + LAG);
    chk("bl_fall_x", bl_fall_x, 640 + LAG);
    chk("line_end_y", d_y, 1);
    chk("line_sn", d_sn, 0);

    // full frame on the short-frame instance, between two frame_start pulses
    cyc = 0; npulse = 0; t0 = 0; t1 = 0;
    vs_lo = 0; bl_hi = 0; fs_hi = 0; max_x = 0; max_y = 0;
    vs_edges = 0; vs_bad_x = 0; p_vs = v_vs;
    while (cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (v_fs) begin
        if (npulse == 1) begin
          t1 = cyc;
          npulse = 2;
          break;
        end
        npulse = 1;
        t0 = cyc;
      end
      if (npulse == 1) begin
        if (!v_vs) vs_lo++;
        if (v_bl) bl_hi++;
        if (v_fs) fs_hi++;
        if (int'(v_x) > max_x) max_x = int'(v_x);
        if (int'(v_y) > max_y) max_y = int'(v_y);
        if (v_vs != p_vs) begin
          vs_edges++;
          if (int'(v_x) != LAG) vs_bad_x++;
        end
      end
      p_vs = v_vs;
    end
    chk("frame_found", npulse, 2);
    chk("frame_period", t1 - t0, 19200);
    chk("frame_vs_low", vs_lo, 3200);
    chk("frame_bl_hi", bl_hi, 7680);
    chk("frame_fs_width", fs_hi, 1);
    chk("frame_max_x", max_x, 799);
    chk("frame_max_y", max_y, 11);
    chk("vs_edges", vs_edges, 2);
    chk("vs_edge_x", vs_bad_x, 0);

    // mid-frame reset at (300,5)
    found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if (v_x == 10'd300 && v_y == 10'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_found", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_x", v_x, 799);
    chk("mid_y", v_y, 11);
    chk("mid_hs", v_hs, 1);
    chk("mid_vs", v_vs, 1);
    chk("mid_bl", v_bl, 0);
    chk("mid_fs", v_fs, 0);
    chk("mid_pe", v_pe, 0);
    chk("mid_dx", d_x, 799);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_rel_x", v_x, 0);
    chk("mid_rel_y", v_y, 0);
    chk("mid_rel_fs", v_fs, 1);
    @(posedge clk);
    #1 chk("mid_rel_fs_off", v_fs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Generates the pixel scan for the 640x480@60 VGA output. Produces the counter_x/counter_y raster counters consumed by every tile renderer and the board overlay.
- Also drives the DAC/connector signals: hsync, vsync, blank_n, sync_n and vga_clk.
- Sits between the 50 MHz board clock and the RGB mux. It is the timing source that the tile renderers sample.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; must be >= 2

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- counter_x  out  10  current pixel column, 0..H_TOTAL-1
- counter_y  out  10  current line, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe; counters advance on the clk edge where pix_en=1
- vga_clk  out  1  pixel clock to the DAC
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  1 while (counter_x,counter_y) is in the visible area
- sync_n  out  1  DAC composite sync, constant 0
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1), combinational from div. vga_clk = (div >= CLK_DIV/2).
- Horizontal counter: on a clk edge with pix_en=1, counter_x increments. When counter_x==H_TOTAL-1 it wraps to 0 and counter_y increments.
- Vertical counter: counter_y wraps to 0 when it is V_TOTAL-1 and counter_x wraps.
- All counters, hsync, vsync, blank_n and frame_start are registers, held stable between pix_en edges.
- Sync/blank timing: hsync, vsync and blank_n are computed from the next-count values. They are therefore always consistent with the counter_x/counter_y shown in the same cycle, with zero latency.
  - hsync = 0 iff H_ACTIVE+H_FP <= counter_x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= counter_y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. vsync changes only at a line boundary, i.e. when counter_x becomes 0.
  - blank_n = (counter_x < H_ACTIVE) && (counter_y < V_ACTIVE).
- frame_start: 1 for exactly one clk cycle, the clk cycle immediately after the edge where the counters become (0,0). 0 otherwise.
- Reset values (asynchronous, while rst_n=0):
  - div=0
  - counter_x=H_TOTAL-1, counter_y=V_TOTAL-1
  - hsync=1, vsync=1, blank_n=0, frame_start=0
  - vga_clk=0, pix_en=0
- Because of these reset values, the first pix_en after reset release wraps the counters to (0,0) and fires frame_start, so the first frame is complete.
- Reset mid-line or mid-frame: all state returns immediately to the reset values. No partial-line state survives.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. No out-of-range values appear, even transiently.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- Defined: hsync, vsync and blank_n pass through one extra register stage, clocked only on pix_en edges. They therefore lag counter_x/counter_y by exactly one pixel period. This matches a downstream registered RGB stage. frame_start and the counters are unchanged. Reset value of the extra stage: hsync=1, vsync=1, blank_n=0.
- Undefined: zero-latency alignment as described in Behaviour.

Test Plan:
- Reset:
  - Hold rst_n=0 for 5 clk -> counter_x=799, counter_y=524, hsync=1, vsync=1, blank_n=0, frame_start=0.
  - Release rst_n -> on the 2nd clk edge counters read (0,0), blank_n=1, and frame_start=1 for one cycle.
- Horizontal line:
  - pix_en period is 2 clk and vga_clk is 50% duty.
  - hsync=0 exactly for counter_x 656..751, i.e. 96 pixels = 192 clk.
  - blank_n goes 1->0 at the transition counter_x 639->640.
- Vertical timing:
  - vsync=0 for lines 490..491 only, i.e. 1600 pixels.
  - blank_n stays 0 for all of lines 480..524.
- Frame wrap:
  - From (799,524), the next pix_en -> (0,0) and frame_start pulses.
  - Consecutive frame_start pulses are exactly 840000 clk apart.
- Mid-frame reset: assert rst_n=0 at (300,200) for 3 clk -> immediate reset values, then clean restart from (0,0) with a frame_start pulse.
- VGA_SYNC_PIPE_EN:
  - Defined -> hsync falls one pixel after counter_x reaches 656, i.e. while counter_x=657.
  - blank_n falls while counter_x=641.
  - Undefined -> the falls occur at 656 and 640.
